lss_shift_ctrl: RTL and testbench
=================================

Name: lss_shift_ctrl

Overview:
Sequencing controller directly upstream of a WIDTH-bit load/shift-left/shift-right register built from lss_reg_bitslice cells. Takes a one-shot command (load, or shift left/right by N with a chosen fill), drives the shared 2-bit mode select c and the two serial edge inputs cycle by cycle, and reports busy/done. The register itself holds the data; this block never sees the parallel word, only the two end bits.

Parameters:
WIDTH, 8, bit width of the attached register
AMT_W, 4, width of shift-amount input; must satisfy 2**AMT_W > WIDTH

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-high reset
start  in  1  command strobe, sampled only in IDLE
op  in  2  00 nop, 01 load, 10 shift left (toward MSB), 11 shift right (toward LSB)
amt  in  AMT_W  shift distance, sampled with start
fill  in  2  00 zero, 01 one, 10 rotate, 11 arithmetic
q_msb  in  1  register bit WIDTH-1
q_lsb  in  1  register bit 0
c  out  2  mode select to every slice: 00 hold, 01 take r_in (shl), 10 parallel load, 11 take l_in (shr)
ser_r  out  1  drives r_in of slice 0 (enters on shl)
ser_l  out  1  drives l_in of slice WIDTH-1 (enters on shr)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (clr=1 at an edge): state IDLE, counter 0, latched op/fill 0; outputs c=00, ser_r=0, ser_l=0, busy=0, done=0. clr overrides start and any operation in flight; the register then holds its current value (c=00), no done pulse.
- States: IDLE, LOAD, SHIFT, DONE. c, ser_*, busy, done are decoded from registered state only (Moore); no combinational path from start/op to c.
- IDLE: c=00. On start=1: op=01 -> LOAD; op=10/11 -> latch op, fill, cnt=min(amt,WIDTH); if cnt=0 go to DONE, else SHIFT; op=00 -> DONE (no register change).
- LOAD: c=10 for exactly one cycle -> DONE. Register captures its parallel input at the edge leaving LOAD.
- SHIFT: c=01 (shl) or 11 (shr) each cycle; cnt decrements every edge; at the edge where cnt goes 1->0, go to DONE. Exactly cnt register updates occur.
- DONE: c=00, done=1, busy=1 for one cycle -> IDLE. start during LOAD/SHIFT/DONE is ignored (no queueing).
- Latency: start sampled at edge k; first register update at edge k+1; last at edge k+cnt; done high in cycle after edge k+cnt; IDLE (busy=0) after edge k+cnt+1. Load: update at k+1, done in following cycle.
- Fill (only meaningful in SHIFT; ser_r/ser_l are 0 in every other state):
  shl: ser_r = 0 (zero), 1 (one), q_msb (rotate), 0 (arithmetic); ser_l=0.
  shr: ser_l = 0, 1, q_lsb (rotate), q_msb (arithmetic, sign hold); ser_r=0.
  Rotate/arith use live q_msb/q_lsb each cycle, so multi-step rotate is exact.
- amt > WIDTH clamps to WIDTH (arith shr by WIDTH yields all sign bits; rotate by WIDTH returns original).
- Counter wide enough for WIDTH; no wrap possible after clamping.

Decomposition:
- Package lss_pkg: op codes (OP_NOP, OP_LOAD, OP_SHL, OP_SHR), c codes (C_HOLD=00, C_SHL=01, C_LOAD=10, C_SHR=11), fill codes, state encoding.
- One sub-module: lss_shift_counter (loadable down-counter with clamp on load, zero flag), instantiated once.

Test Plan (bench wraps 8 lss_reg_bitslice cells, WIDTH=8):
- Load 8'hA5, then shl amt=3 fill zero -> c=01 for 3 cycles, reg=8'h28, done pulses once 4 cycles after start.
- Load 8'h96, shr amt=2 fill arithmetic -> reg=8'hE5; repeat with fill zero -> 8'h25.
- Load 8'h81, rotate shl amt=1 -> 8'h03; rotate shr amt=9 (clamped 8) -> 8'h81, exactly 8 shift cycles.
- shl amt=0 and op=00 -> no c activity, reg unchanged, done in cycle after start, busy 1 cycle.
- start reasserted every cycle during a 5-step shift -> ignored, exactly 5 updates, single done.
- clr asserted at 2nd cycle of shr amt=6 fill one -> next cycle c=00, busy=0, done never pulses, reg reflects exactly 2 shifts (8'h00 loaded -> 8'hC0).

Source files
------------

// File: rtl/lss_pkg.sv
// Shared encodings for the load/shift sequencing controller.
package lss_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_LOAD = 2'b01,
      OP_SHL  = 2'b10,
      OP_SHR  = 2'b11
   } op_e;

   // Mode select broadcast to every register slice.
   typedef enum logic [1:0] {
      C_HOLD = 2'b00,
      C_SHL  = 2'b01,
      C_LOAD = 2'b10,
      C_SHR  = 2'b11
   } c_e;

   typedef enum logic [1:0] {
      FILL_ZERO  = 2'b00,
      FILL_ONE   = 2'b01,
      FILL_ROT   = 2'b10,
      FILL_ARITH = 2'b11
   } fill_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // Counter width able to hold the full register width after clamping.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/lss_shift_counter.sv
// Loadable down-counter for the remaining shift steps; amounts past WIDTH clamp to WIDTH.
module lss_shift_counter
   import lss_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ld,
   input  logic             dec,
   input  logic [AMT_W-1:0] amt,
   output logic             last,
   output logic             ld_zero
);

   localparam int CNT_W = cnt_width(WIDTH);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] amt_c;

   always_comb begin
      amt_c = CNT_W'(WIDTH);
      if (amt <= AMT_W'(WIDTH)) amt_c = CNT_W'(amt);
   end

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (ld)
         cnt <= amt_c;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign last    = (cnt == CNT_W'(1));
   assign ld_zero = (amt == '0);

endmodule

// File: rtl/lss_shift_ctrl.sv
// Moore sequencer driving mode select and serial edge bits of a load/shift register.
module lss_shift_ctrl
   import lss_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [AMT_W-1:0] amt,
   input  logic [1:0]       fill,
   input  logic             q_msb,
   input  logic             q_lsb,
   output logic [1:0]       c,
   output logic             ser_r,
   output logic             ser_l,
   output logic             busy,
   output logic             done
);

   state_e state_q, state_d;
   op_e    op_q;
   fill_e  fill_q;
   logic   cnt_ld, cnt_dec, cnt_last, amt_zero;
   logic   is_shift_op;

   assign is_shift_op = (op_e'(op) == OP_SHL) || (op_e'(op) == OP_SHR);
   assign cnt_ld      = (state_q == ST_IDLE) && start && is_shift_op;
   assign cnt_dec     = (state_q == ST_SHIFT);

   lss_shift_counter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) u_cnt (
      .clk     (clk),
      .clr     (clr),
      .ld      (cnt_ld),
      .dec     (cnt_dec),
      .amt     (amt),
      .last    (cnt_last),
      .ld_zero (amt_zero)
   );

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         fill_q  <= FILL_ZERO;
      end else begin
         state_q <= state_d;
         if (cnt_ld) begin
            op_q   <= op_e'(op);
            fill_q <= fill_e'(fill);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      c       = C_HOLD;
      ser_r   = 1'b0;
      ser_l   = 1'b0;
      busy    = (state_q != ST_IDLE);
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               unique case (op_e'(op))
                  OP_LOAD:        state_d = ST_LOAD;
                  OP_SHL, OP_SHR: state_d = amt_zero ? ST_DONE : ST_SHIFT;
                  default:        state_d = ST_DONE;
               endcase
            end
         end
         ST_LOAD: begin
            c       = C_LOAD;
            state_d = ST_DONE;
         end
         ST_SHIFT: begin
            // Rotate/arith read the live edge bits so each step sees the previous one.
            if (op_q == OP_SHL) begin
               c = C_SHL;
               unique case (fill_q)
                  FILL_ONE: ser_r = 1'b1;
                  FILL_ROT: ser_r = q_msb;
                  default:  ser_r = 1'b0;
               endcase
            end else begin
               c = C_SHR;
               unique case (fill_q)
                  FILL_ONE:   ser_l = 1'b1;
                  FILL_ROT:   ser_l = q_lsb;
                  FILL_ARITH: ser_l = q_msb;
                  default:    ser_l = 1'b0;
               endcase
            end
            if (cnt_last) state_d = ST_DONE;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_lss_shift_ctrl.sv
// Directed bench: controller drives a behavioural 8-bit load/shift register; scoreboard checks on done.
module tb_lss_shift_ctrl;
   import lss_pkg::*;

   localparam int WIDTH = 8;
   localparam int AMT_W = 4;

   logic             clk = 1'b0;
   logic             clr, start;
   logic [1:0]       op, fill;
   logic [AMT_W-1:0] amt;
   logic             q_msb, q_lsb;
   logic [1:0]       c;
   logic             ser_r, ser_l, busy, done;
   logic [WIDTH-1:0] rq = '0;
   logic [WIDTH-1:0] din;

   typedef struct {
      logic [WIDTH-1:0] r;
      int               nshl;
      int               nshr;
      int               lat;
   } exp_t;

   exp_t sb[$];
   int   st_q[$];
   int   checks = 0, errors = 0, cyc = 0, ndone = 0;
   int   sc_l = 0, sc_r = 0, bc = 0;

   always #5 clk = ~clk;

   lss_shift_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .op    (op),
      .amt   (amt),
      .fill  (fill),
      .q_msb (q_msb),
      .q_lsb (q_lsb),
      .c     (c),
      .ser_r (ser_r),
      .ser_l (ser_l),
      .busy  (busy),
      .done  (done)
   );

   // Attached register: slice 0 takes ser_r on shl, slice WIDTH-1 takes ser_l on shr.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      case (c)
         2'b01:   rq <= {rq[WIDTH-2:0], ser_r};
         2'b10:   rq <= din;
         2'b11:   rq <= {ser_l, rq[WIDTH-1:1]};
         default: rq <= rq;
      endcase
   end

   assign q_msb = rq[WIDTH-1];
   assign q_lsb = rq[0];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run(input logic [1:0] o, input int a, input logic [1:0] f,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] er,
                      input int nl, input int nr, input int lat, input bit hammer);
      exp_t e;
      e.r = er; e.nshl = nl; e.nshr = nr; e.lat = lat;
      sb.push_back(e);
      @(negedge clk);
      op = o; amt = a[AMT_W-1:0]; fill = f; din = d; start = 1'b1;
      st_q.push_back(cyc + 1);
      @(negedge clk);
      start = hammer;
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         if (hammer) start = !done;
         @(negedge clk);
      end
      start = 1'b0;
      if (busy) chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; op = '0; amt = '0; fill = '0; din = '0;

      fork
         forever begin
            exp_t e;
            int   s;
            @(negedge clk);
            if (clr || !busy) begin
               sc_l = 0; sc_r = 0; bc = 0;
            end else begin
               bc++;
               if (c == 2'b01) sc_l++;
               if (c == 2'b11) sc_r++;
            end
            if (done) begin
               ndone++;
               if (sb.size() == 0) begin
                  chk("unexpected_done", int'(done), 0);
               end else begin
                  e = sb.pop_front();
                  s = st_q.pop_front();
                  chk("reg_value", int'(rq), int'(e.r));
                  chk("shl_cycles", sc_l, e.nshl);
                  chk("shr_cycles", sc_r, e.nshr);
                  chk("done_latency", cyc - s, e.lat);
                  chk("busy_cycles", bc, e.lat + 1);
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      chk("rst_c", int'(c), 0);
      chk("rst_ser_r", int'(ser_r), 0);
      chk("rst_ser_l", int'(ser_l), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      clr = 1'b0;

      //   op     amt fill   din    exp    shl shr lat hammer
      run(2'b01, 0, 2'b00, 8'hA5, 8'hA5, 0, 0, 1, 0);
      run(2'b10, 3, 2'b00, 8'h00, 8'h28, 3, 0, 3, 0);
      run(2'b01, 0, 2'b00, 8'h96, 8'h96, 0, 0, 1, 0);
      run(2'b11, 2, 2'b11, 8'h00, 8'hE5, 0, 2, 2, 0);
      run(2'b01, 0, 2'b00, 8'h96, 8'h96, 0, 0, 1, 0);
      run(2'b11, 2, 2'b00, 8'h00, 8'h25, 0, 2, 2, 0);
      run(2'b01, 0, 2'b00, 8'h81, 8'h81, 0, 0, 1, 0);
      run(2'b10, 1, 2'b10, 8'h00, 8'h03, 1, 0, 1, 0);
      run(2'b01, 0, 2'b00, 8'h81, 8'h81, 0, 0, 1, 0);
      run(2'b11, 9, 2'b10, 8'h00, 8'h81, 0, 8, 8, 0);
      run(2'b10, 0, 2'b00, 8'h00, 8'h81, 0, 0, 0, 0);
      run(2'b00, 5, 2'b01, 8'hFF, 8'h81, 0, 0, 0, 0);
      run(2'b01, 0, 2'b00, 8'h0F, 8'h0F, 0, 0, 1, 0);
      run(2'b10, 5, 2'b10, 8'h00, 8'hE1, 5, 0, 5, 1);
      run(2'b01, 0, 2'b00, 8'h00, 8'h00, 0, 0, 1, 0);

      // Abort a 6-step shr fill-one during its second shift cycle.
      @(negedge clk);
      op = 2'b11; amt = 4'd6; fill = 2'b01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      chk("clr_c", int'(c), 0);
      chk("clr_busy", int'(busy), 0);
      chk("clr_done", int'(done), 0);
      chk("clr_reg", int'(rq), 8'hC0);
      clr = 1'b0;
      repeat (10) @(negedge clk);
      chk("clr_reg_hold", int'(rq), 8'hC0);
      chk("done_count", ndone, 15);
      chk("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
